// File: rtl/sdram_arb_pkg.sv
// sdram_arb_pkg: shared widths, read return tag and arbiter FSM state
// for the sdram_arbiter slice.
package sdram_arb_pkg;

    localparam int ADDR_W = 20;
    localparam int LEN_W  = 4;
    localparam int DATA_W = 16;
    localparam int PORT_W = 2;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [LEN_W-1:0]  len;
    } rd_tag_t;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } arb_state_t;

    // Round-robin successor of port p among n ports.
    function automatic logic [PORT_W-1:0] next_port(
        input logic [PORT_W-1:0] p,
        input int                n
    );
        if (int'(p) >= n - 1) return '0;
        return p + PORT_W'(1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: picks the first requester at or after ptr (wrapping).
// Ports: req/ptr/en in; one-hot grant, grant index and valid out.
module rr_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int N = 3
) (
    input  logic [N-1:0]      req,
    input  logic [PORT_W-1:0] ptr,
    input  logic              en,
    output logic [N-1:0]      grant,
    output logic [PORT_W-1:0] idx,
    output logic              valid
);

    logic              hi_v;
    logic              lo_v;
    logic [PORT_W-1:0] hi_i;
    logic [PORT_W-1:0] lo_i;

    // Scan downward so the lowest matching port wins; hi_* covers ports
    // at/after ptr, lo_* is the wrap-around fallback.
    always_comb begin
        hi_v = 1'b0;
        lo_v = 1'b0;
        hi_i = '0;
        lo_i = '0;
        for (int p = N - 1; p >= 0; p--) begin
            if (req[p]) begin
                lo_v = 1'b1;
                lo_i = PORT_W'(p);
                if (PORT_W'(p) >= ptr) begin
                    hi_v = 1'b1;
                    hi_i = PORT_W'(p);
                end
            end
        end
        valid = en && lo_v;
        idx   = hi_v ? hi_i : lo_i;
        grant = '0;
        for (int p = 0; p < N; p++) begin
            grant[p] = valid && (idx == PORT_W'(p));
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin sharing of one sdram controller's read and
// write channels among NPORTS clients, with a read return queue that
// routes rd_rdy beats to the owning client. Ports: cli_* client side,
// rd_*/wr_* controller side, err_stray sticky stray-data flag.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int NPORTS   = 3,
    parameter int RQ_DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NPORTS*ADDR_W-1:0] cli_rd_addr,
    input  logic [NPORTS*LEN_W-1:0]  cli_rd_len,
    input  logic [NPORTS-1:0]        cli_rd_req,
    output logic [NPORTS-1:0]        cli_rd_ack,
    output logic [DATA_W-1:0]        cli_rd_data,
    output logic [NPORTS-1:0]        cli_rd_rdy,
    input  logic [NPORTS*ADDR_W-1:0] cli_wr_addr,
    input  logic [NPORTS*DATA_W-1:0] cli_wr_data,
    input  logic [NPORTS*LEN_W-1:0]  cli_wr_len,
    input  logic [NPORTS-1:0]        cli_wr_req,
    output logic [NPORTS-1:0]        cli_wr_ack,
    output logic [ADDR_W-1:0]        rd_addr,
    output logic [LEN_W-1:0]         rd_len,
    output logic                     rd_req,
    input  logic                     rd_ack,
    input  logic [DATA_W-1:0]        rd_data,
    input  logic                     rd_rdy,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic [DATA_W-1:0]        wr_data,
    output logic [LEN_W-1:0]         wr_len,
    output logic                     wr_req,
    input  logic                     wr_ack,
    output logic                     err_stray
);

    localparam int QW = (RQ_DEPTH > 1) ? $clog2(RQ_DEPTH) : 1;

    // ---------------- read channel ----------------
    arb_state_t        rd_state;
    arb_state_t        rd_state_nx;
    logic [PORT_W-1:0] rd_ptr;
    logic [PORT_W-1:0] rd_g;
    logic [NPORTS-1:0] rd_oh;
    logic [NPORTS-1:0] rd_gnt;
    logic [PORT_W-1:0] rd_idx;
    logic              rd_gv;
    logic              rd_en;
    logic              rd_busy;
    logic              rd_push;
    logic [ADDR_W-1:0] rd_addr_mx;
    logic [LEN_W-1:0]  rd_len_mx;

    // ---------------- return queue ----------------
    rd_tag_t           rq [RQ_DEPTH];
    rd_tag_t           hd;
    logic [QW-1:0]     head;
    logic [QW-1:0]     tail;
    logic [QW:0]       fill;
    logic [LEN_W-1:0]  beat;
    logic              empty;
    logic              rd_pop;

    // ---------------- write channel ----------------
    arb_state_t        wr_state;
    arb_state_t        wr_state_nx;
    logic [PORT_W-1:0] wr_ptr;
    logic [PORT_W-1:0] wr_g;
    logic [NPORTS-1:0] wr_oh;
    logic [NPORTS-1:0] wr_gnt;
    logic [PORT_W-1:0] wr_idx;
    logic              wr_gv;
    logic              wr_en;
    logic              wr_busy;
    logic              wr_done;
    logic [ADDR_W-1:0] wr_addr_mx;
    logic [DATA_W-1:0] wr_data_mx;
    logic [LEN_W-1:0]  wr_len_mx;

    assign rd_busy = (rd_state == REQ);
    assign wr_busy = (wr_state == REQ);
    assign rd_push = rd_busy && rd_ack;
    assign wr_done = wr_busy && wr_ack;

    // Reserve a slot for a burst still waiting on rd_ack so its push
    // can never overflow the queue.
    assign rd_en = (rd_state == IDLE)
                && (int'(fill) + int'(rd_busy) < RQ_DEPTH);
    assign wr_en = (wr_state == IDLE);

    rr_arbiter #(.N(NPORTS)) u_rd_rr (
        .req   (cli_rd_req),
        .ptr   (rd_ptr),
        .en    (rd_en),
        .grant (rd_gnt),
        .idx   (rd_idx),
        .valid (rd_gv)
    );

    rr_arbiter #(.N(NPORTS)) u_wr_rr (
        .req   (cli_wr_req),
        .ptr   (wr_ptr),
        .en    (wr_en),
        .grant (wr_gnt),
        .idx   (wr_idx),
        .valid (wr_gv)
    );

    // Field muxes for the port being granted this cycle.
    always_comb begin
        rd_addr_mx = '0;
        rd_len_mx  = '0;
        wr_addr_mx = '0;
        wr_data_mx = '0;
        wr_len_mx  = '0;
        for (int p = 0; p < NPORTS; p++) begin
            if (rd_idx == PORT_W'(p)) begin
                rd_addr_mx = cli_rd_addr[p*ADDR_W +: ADDR_W];
                rd_len_mx  = cli_rd_len[p*LEN_W +: LEN_W];
            end
            if (wr_idx == PORT_W'(p)) begin
                wr_addr_mx = cli_wr_addr[p*ADDR_W +: ADDR_W];
                wr_data_mx = cli_wr_data[p*DATA_W +: DATA_W];
                wr_len_mx  = cli_wr_len[p*LEN_W +: LEN_W];
            end
        end
    end

    // ---------------- FSM next state ----------------
    always_comb begin
        rd_state_nx = rd_state;
        case (rd_state)
            IDLE: if (rd_gv)  rd_state_nx = REQ;
            REQ:  if (rd_ack) rd_state_nx = IDLE;
        endcase
    end

    always_comb begin
        wr_state_nx = wr_state;
        case (wr_state)
            IDLE: if (wr_gv)  wr_state_nx = REQ;
            REQ:  if (wr_ack) wr_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state <= IDLE;
            wr_state <= IDLE;
        end else begin
            rd_state <= rd_state_nx;
            wr_state <= wr_state_nx;
        end
    end

    // ---------------- read request registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr  <= '0;
            rd_g    <= '0;
            rd_oh   <= '0;
            rd_req  <= 1'b0;
            rd_addr <= '0;
            rd_len  <= '0;
        end else if (rd_gv) begin
            rd_g    <= rd_idx;
            rd_oh   <= rd_gnt;
            rd_req  <= 1'b1;
            rd_addr <= rd_addr_mx;
            rd_len  <= rd_len_mx;
        end else if (rd_push) begin
            rd_req  <= 1'b0;
            rd_ptr  <= next_port(rd_g, NPORTS);
        end
    end

    // ---------------- write request registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            wr_g    <= '0;
            wr_oh   <= '0;
            wr_req  <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            wr_len  <= '0;
        end else if (wr_gv) begin
            wr_g    <= wr_idx;
            wr_oh   <= wr_gnt;
            wr_req  <= 1'b1;
            wr_addr <= wr_addr_mx;
            wr_data <= wr_data_mx;
            wr_len  <= wr_len_mx;
        end else if (wr_done) begin
            wr_req  <= 1'b0;
            wr_ptr  <= next_port(wr_g, NPORTS);
        end
    end

    assign cli_rd_ack = rd_oh & {NPORTS{rd_push}};
    assign cli_wr_ack = wr_oh & {NPORTS{wr_done}};

    // ---------------- return queue ----------------
    assign hd     = rq[head];
    assign empty  = (fill == '0);
    assign rd_pop = rd_rdy && !empty && (beat == hd.len);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RQ_DEPTH; i++) begin
                rq[i] <= '0;
            end
            head      <= '0;
            tail      <= '0;
            fill      <= '0;
            beat      <= '0;
            err_stray <= 1'b0;
        end else begin
            if (rd_push) begin
                rq[tail] <= '{port: rd_g, len: rd_len};
                tail     <= tail + 1'b1;
            end
            if (rd_pop) begin
                head <= head + 1'b1;
            end
            if (rd_push && !rd_pop) begin
                fill <= fill + 1'b1;
            end else if (rd_pop && !rd_push) begin
                fill <= fill - 1'b1;
            end
            if (rd_rdy && !empty) begin
                beat <= rd_pop ? '0 : beat + 1'b1;
            end
            if (rd_rdy && empty) begin
                err_stray <= 1'b1;
            end
        end
    end

    assign cli_rd_data = rd_data;

    always_comb begin
        cli_rd_rdy = '0;
        for (int p = 0; p < NPORTS; p++) begin
            cli_rd_rdy[p] = rd_rdy && !empty && (hd.port == PORT_W'(p));
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter (3 ports, depth 2).
// Inputs change 1ns after posedge; checks run 1-2ns after the edge.
module tb_sdram_arbiter;

    localparam int NP = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [NP*20-1:0] cli_rd_addr;
    logic [NP*4-1:0]  cli_rd_len;
    logic [NP-1:0]    cli_rd_req;
    logic [NP-1:0]    cli_rd_ack;
    logic [15:0]      cli_rd_data;
    logic [NP-1:0]    cli_rd_rdy;
    logic [NP*20-1:0] cli_wr_addr;
    logic [NP*16-1:0] cli_wr_data;
    logic [NP*4-1:0]  cli_wr_len;
    logic [NP-1:0]    cli_wr_req;
    logic [NP-1:0]    cli_wr_ack;
    logic [19:0]      rd_addr;
    logic [3:0]       rd_len;
    logic             rd_req;
    logic             rd_ack;
    logic [15:0]      rd_data;
    logic             rd_rdy;
    logic [19:0]      wr_addr;
    logic [15:0]      wr_data;
    logic [3:0]       wr_len;
    logic             wr_req;
    logic             wr_ack;
    logic             err_stray;

    int tests = 0;
    int fails = 0;

    sdram_arbiter #(.NPORTS(NP), .RQ_DEPTH(2)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cli_rd_addr (cli_rd_addr),
        .cli_rd_len  (cli_rd_len),
        .cli_rd_req  (cli_rd_req),
        .cli_rd_ack  (cli_rd_ack),
        .cli_rd_data (cli_rd_data),
        .cli_rd_rdy  (cli_rd_rdy),
        .cli_wr_addr (cli_wr_addr),
        .cli_wr_data (cli_wr_data),
        .cli_wr_len  (cli_wr_len),
        .cli_wr_req  (cli_wr_req),
        .cli_wr_ack  (cli_wr_ack),
        .rd_addr     (rd_addr),
        .rd_len      (rd_len),
        .rd_req      (rd_req),
        .rd_ack      (rd_ack),
        .rd_data     (rd_data),
        .rd_rdy      (rd_rdy),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_len      (wr_len),
        .wr_req      (wr_req),
        .wr_ack      (wr_ack),
        .err_stray   (err_stray)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic wait_rd_req();
        int n = 0;
        while (rd_req !== 1'b1 && n < 20) begin
            cyc();
            n++;
        end
        chk("rd_req_wait", 32'(rd_req), 32'd1);
    endtask

    task automatic set_rd(input int p, input logic [19:0] a,
                          input logic [3:0] l);
        cli_rd_addr[p*20 +: 20] = a;
        cli_rd_len[p*4 +: 4]    = l;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int seen;
        int e;
        reset_n     = 1'b0;
        cli_rd_addr = '0;
        cli_rd_len  = '0;
        cli_rd_req  = '0;
        cli_wr_addr = '0;
        cli_wr_data = '0;
        cli_wr_len  = '0;
        cli_wr_req  = '0;
        rd_ack      = 1'b0;
        rd_data     = '0;
        rd_rdy      = 1'b0;
        wr_ack      = 1'b0;

        // reset state
        #2;
        chk("rst_rd_req", 32'(rd_req), 0);
        chk("rst_wr_req", 32'(wr_req), 0);
        chk("rst_rd_addr", 32'(rd_addr), 0);
        chk("rst_acks", 32'({cli_rd_ack, cli_wr_ack}), 0);
        chk("rst_rdy", 32'(cli_rd_rdy), 0);
        chk("rst_stray", 32'(err_stray), 0);
        cyc();
        reset_n = 1'b1;
        cyc();

        // queue full: three len-0 reads, no data returned
        set_rd(0, 20'h00010, 4'd0);
        set_rd(1, 20'h00020, 4'd0);
        set_rd(2, 20'h00030, 4'd0);
        cli_rd_req = 3'b111;
        cyc();
        chk("qf_req0", 32'(rd_req), 1);
        chk("qf_addr0", 32'(rd_addr), 32'h00010);
        cyc();
        rd_ack = 1'b1;
        settle();
        chk("qf_ack0", 32'(cli_rd_ack), 32'b001);
        cli_rd_req = 3'b110;
        cyc();
        rd_ack = 1'b0;
        cyc();
        chk("qf_req1", 32'(rd_req), 1);
        chk("qf_addr1", 32'(rd_addr), 32'h00020);
        cyc();
        rd_ack = 1'b1;
        settle();
        chk("qf_ack1", 32'(cli_rd_ack), 32'b010);
        cli_rd_req = 3'b100;
        cyc();
        rd_ack = 1'b0;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (rd_req) seen++;
        end
        chk("qf_blocked", 32'(seen), 0);
        rd_rdy = 1'b1;
        settle();
        chk("qf_beat0", 32'(cli_rd_rdy), 32'b001);
        cyc();
        rd_rdy = 1'b0;
        wait_rd_req();
        chk("qf_addr2", 32'(rd_addr), 32'h00030);
        cyc();
        rd_ack = 1'b1;
        rd_rdy = 1'b1;
        settle();
        chk("qf_ack2", 32'(cli_rd_ack), 32'b100);
        chk("qf_beat1", 32'(cli_rd_rdy), 32'b010);
        cli_rd_req = 3'b000;
        cyc();
        rd_ack = 1'b0;
        settle();
        chk("qf_beat2", 32'(cli_rd_rdy), 32'b100);
        cyc();
        rd_rdy = 1'b0;
        chk("qf_nostray", 32'(err_stray), 0);

        // single read: port 0, addr 0x00100, len 3
        set_rd(0, 20'h00100, 4'd3);
        cli_rd_req = 3'b001;
        settle();
        chk("sr_req_c0", 32'(rd_req), 0);
        cyc();
        chk("sr_req_c1", 32'(rd_req), 1);
        chk("sr_addr", 32'(rd_addr), 32'h00100);
        chk("sr_len", 32'(rd_len), 3);
        cyc();
        chk("sr_noack_c2", 32'(cli_rd_ack), 0);
        cyc();
        rd_ack = 1'b1;
        settle();
        chk("sr_ack_c3", 32'(cli_rd_ack), 32'b001);
        cli_rd_req = 3'b000;
        cyc();
        rd_ack = 1'b0;
        chk("sr_req_drop", 32'(rd_req), 0);
        for (int b = 0; b < 4; b++) begin
            rd_rdy  = 1'b1;
            rd_data = 16'(16'h1111 * (b + 1));
            settle();
            chk("sr_rdy", 32'(cli_rd_rdy), 32'b001);
            chk("sr_data", 32'(cli_rd_data), 32'(16'h1111 * (b + 1)));
            cyc();
        end

        // stray beat: queue must now be empty
        rd_rdy = 1'b1;
        settle();
        chk("stray_rdy", 32'(cli_rd_rdy), 0);
        cyc();
        rd_rdy = 1'b0;
        chk("stray_flag", 32'(err_stray), 1);
        cyc();
        cyc();
        chk("stray_sticky", 32'(err_stray), 1);

        // fairness: ports 0 and 1 both request; pointer now at 1
        set_rd(0, 20'hA0000, 4'd0);
        set_rd(1, 20'hB1111, 4'd0);
        cli_rd_req = 3'b011;
        for (int i = 0; i < 4; i++) begin
            e = (i % 2 == 0) ? 1 : 0;
            wait_rd_req();
            chk("fair_addr", 32'(rd_addr), (e == 1) ? 32'hB1111 : 32'hA0000);
            cyc();
            rd_ack = 1'b1;
            settle();
            chk("fair_ack", 32'(cli_rd_ack), 32'(1 << e));
            if (i == 3) cli_rd_req = 3'b000;
            cyc();
            rd_ack = 1'b0;
            rd_rdy = 1'b1;
            settle();
            chk("fair_rdy", 32'(cli_rd_rdy), 32'(1 << e));
            cyc();
            rd_rdy = 1'b0;
        end

        // write from port 2 while a port 0 read waits in REQ
        set_rd(0, 20'h00200, 4'd0);
        cli_wr_addr = {20'h12345, 20'h11111, 20'hFFFFF};
        cli_wr_data = {16'hBEEF, 16'h5555, 16'hAAAA};
        cli_wr_len  = {4'h0, 4'h7, 4'hF};
        cli_rd_req  = 3'b001;
        cli_wr_req  = 3'b100;
        cyc();
        chk("wr_rd_req", 32'(rd_req), 1);
        chk("wr_req", 32'(wr_req), 1);
        chk("wr_addr", 32'(wr_addr), 32'h12345);
        chk("wr_data", 32'(wr_data), 32'hBEEF);
        chk("wr_len", 32'(wr_len), 0);
        cyc();
        wr_ack = 1'b1;
        settle();
        chk("wr_ack", 32'(cli_wr_ack), 32'b100);
        chk("wr_no_rdack", 32'(cli_rd_ack), 0);
        cli_wr_req = 3'b000;
        cyc();
        wr_ack = 1'b0;
        chk("wr_req_drop", 32'(wr_req), 0);
        chk("wr_rd_held", 32'(rd_req), 1);
        chk("wr_rd_addr", 32'(rd_addr), 32'h00200);
        rd_ack = 1'b1;
        settle();
        chk("wr_rd_ack", 32'(cli_rd_ack), 32'b001);
        cli_rd_req = 3'b000;
        cyc();
        rd_ack = 1'b0;
        rd_rdy = 1'b1;
        settle();
        chk("wr_rd_rdy", 32'(cli_rd_rdy), 32'b001);
        cyc();
        rd_rdy = 1'b0;

        // reset mid-burst
        set_rd(1, 20'h0ABCD, 4'd3);
        cli_rd_req = 3'b010;
        wait_rd_req();
        chk("mb_addr", 32'(rd_addr), 32'h0ABCD);
        cyc();
        rd_ack = 1'b1;
        settle();
        chk("mb_ack", 32'(cli_rd_ack), 32'b010);
        cli_rd_req = 3'b000;
        cyc();
        rd_ack = 1'b0;
        for (int b = 0; b < 2; b++) begin
            rd_rdy = 1'b1;
            settle();
            chk("mb_rdy", 32'(cli_rd_rdy), 32'b010);
            cyc();
        end
        rd_rdy  = 1'b1;
        reset_n = 1'b0;
        settle();
        chk("mb_rst_rdy", 32'(cli_rd_rdy), 0);
        chk("mb_rst_stray", 32'(err_stray), 0);
        chk("mb_rst_rd_req", 32'(rd_req), 0);
        chk("mb_rst_rd_addr", 32'(rd_addr), 0);
        chk("mb_rst_rd_len", 32'(rd_len), 0);
        chk("mb_rst_wr", 32'({wr_addr, wr_data, wr_len}), 0);
        chk("mb_rst_acks", 32'({cli_rd_ack, cli_wr_ack}), 0);
        rd_rdy = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        set_rd(1, 20'h0F00F, 4'd1);
        cli_rd_req = 3'b010;
        wait_rd_req();
        chk("pr_addr", 32'(rd_addr), 32'h0F00F);
        chk("pr_len", 32'(rd_len), 1);
        cyc();
        rd_ack = 1'b1;
        settle();
        chk("pr_ack", 32'(cli_rd_ack), 32'b010);
        cli_rd_req = 3'b000;
        cyc();
        rd_ack = 1'b0;
        for (int b = 0; b < 2; b++) begin
            rd_rdy = 1'b1;
            settle();
            chk("pr_rdy", 32'(cli_rd_rdy), 32'b010);
            cyc();
        end
        rd_rdy = 1'b1;
        settle();
        chk("pr_extra_rdy", 32'(cli_rd_rdy), 0);
        cyc();
        rd_rdy = 1'b0;
        chk("pr_extra_stray", 32'(err_stray), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
